// File: rtl/mem_banked_xbar.sv
// mem_banked_xbar: multi-port, multi-bank synchronous SRAM behind a per-bank arbitrating crossbar.
// Optional simulation checks are compiled when MEM_BANKED_XBAR_CHECK_EN is defined.

`ifdef MEM_BANKED_XBAR_CHECK_EN
module mem_banked_xbar_checker #(
    parameter int num_ports_p = 2,
    parameter int num_banks_p = 1
) (
    input logic                                 clk_i,
    input logic                                 reset_n_i,
    input logic [num_ports_p-1:0]               v_i,
    input logic [num_ports_p-1:0]               w_i,
    input logic [num_ports_p-1:0]               oor_i,
    input logic [num_banks_p*num_ports_p-1:0]   grant_i
);
    // Mid-cycle protocol checks, once the combinational request and grant values have settled.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1) begin
            if ($isunknown(v_i)) begin
                $error("mem_banked_xbar: X/Z on v_i (%b)", v_i);
                $finish;
            end
            for (int p = 0; p < num_ports_p; p++) begin
                if (v_i[p] && $isunknown(w_i[p])) begin
                    $error("mem_banked_xbar: X/Z on w_i of valid port %0d", p);
                    $finish;
                end
                if (v_i[p] && oor_i[p]) begin
                    $error("mem_banked_xbar: out-of-range address on port %0d", p);
                    $finish;
                end
            end
            for (int b = 0; b < num_banks_p; b++) begin
                if ($countones(grant_i[b*num_ports_p +: num_ports_p]) > 1) begin
                    $error("mem_banked_xbar: multiple grants in bank %0d", b);
                    $finish;
                end
            end
        end
    end
endmodule
`endif

module mem_banked_xbar #(
    parameter int num_ports_p  = 2,
    parameter int num_banks_p  = 1,
    parameter int bank_size_p  = 1024,
    parameter int data_width_p = 32,
    parameter int rr_lo_hi_p   = 0,
    localparam int addr_width_lp = $clog2(bank_size_p) + $clog2(num_banks_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    reverse_pr_i,
    input  logic [num_ports_p-1:0]                  v_i,
    input  logic [num_ports_p-1:0]                  w_i,
    input  logic [num_ports_p*addr_width_lp-1:0]    addr_i,
    input  logic [num_ports_p*data_width_p-1:0]     data_i,
    input  logic [num_ports_p*(data_width_p/8)-1:0] mask_i,
    output logic [num_ports_p-1:0]                  yumi_o,
    output logic [num_ports_p-1:0]                  v_o,
    output logic [num_ports_p*data_width_p-1:0]     data_o
);
    localparam int bank_bits_lp = $clog2(num_banks_p);
    localparam int bank_w_lp    = (bank_bits_lp > 0) ? bank_bits_lp : 1;
    localparam int idx_bits_lp  = $clog2(bank_size_p);
    localparam int idx_w_lp     = (idx_bits_lp > 0) ? idx_bits_lp : 1;
    localparam int port_w_lp    = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
    localparam int bytes_lp     = data_width_p / 8;

    logic [addr_width_lp-1:0] addr_s  [num_ports_p];
    logic [bank_w_lp-1:0]     bank_s  [num_ports_p];
    logic [idx_w_lp-1:0]      idx_s   [num_ports_p];
    logic [num_ports_p-1:0]   oor_s;
    logic [num_ports_p-1:0]   req_s   [num_banks_p];
    logic [num_ports_p-1:0]   grant_s [num_banks_p];
    logic [port_w_lp-1:0]     win_s   [num_banks_p];
    logic [num_banks_p-1:0]   any_s;
    logic [num_ports_p-1:0]   yumi_s;

    logic [port_w_lp-1:0]     rr_ptr_r [num_banks_p];
    logic [num_ports_p-1:0]   v_r;
    logic [data_width_p-1:0]  data_r   [num_ports_p];
    logic [data_width_p-1:0]  mem_r    [num_banks_p][bank_size_p];

    function automatic logic [port_w_lp-1:0] pick_high(input logic [num_ports_p-1:0] req);
        pick_high = '0;
        for (int p = 0; p < num_ports_p; p++)
            if (req[p]) pick_high = port_w_lp'(p);
    endfunction

    function automatic logic [port_w_lp-1:0] pick_low(input logic [num_ports_p-1:0] req);
        pick_low = '0;
        for (int p = num_ports_p - 1; p >= 0; p--)
            if (req[p]) pick_low = port_w_lp'(p);
    endfunction

    // Scan backwards from the farthest offset so the nearest requester at or after ptr wins.
    function automatic logic [port_w_lp-1:0] pick_rr(input logic [num_ports_p-1:0] req,
                                                     input logic [port_w_lp-1:0]   ptr);
        pick_rr = '0;
        for (int k = num_ports_p - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % num_ports_p]) pick_rr = port_w_lp'((int'(ptr) + k) % num_ports_p);
    endfunction

    function automatic logic [port_w_lp-1:0] next_ptr(input logic [port_w_lp-1:0] win);
        next_ptr = port_w_lp'((int'(win) + 1) % num_ports_p);
    endfunction

    // Address decode: low bits pick the bank, the rest index the word inside it.
    always_comb begin
        for (int p = 0; p < num_ports_p; p++) begin
            addr_s[p] = addr_i[p*addr_width_lp +: addr_width_lp];
            bank_s[p] = bank_w_lp'(addr_s[p]) & bank_w_lp'(num_banks_p - 1);
            idx_s[p]  = idx_w_lp'(addr_s[p] >> bank_bits_lp);
            oor_s[p]  = ({1'b0, idx_s[p]} >= (idx_w_lp + 1)'(bank_size_p));
        end
    end

    // Per-bank arbitration; yumi is the union of every bank's single grant.
    always_comb begin
        req_s   = '{default: '0};
        grant_s = '{default: '0};
        win_s   = '{default: '0};
        any_s   = '0;
        yumi_s  = '0;
        for (int b = 0; b < num_banks_p; b++) begin
            for (int p = 0; p < num_ports_p; p++)
                req_s[b][p] = v_i[p] & (bank_s[p] == bank_w_lp'(b));
            any_s[b] = |req_s[b];
            if (rr_lo_hi_p == 2) begin
                win_s[b] = pick_rr(req_s[b], rr_ptr_r[b]);
            end else if ((rr_lo_hi_p == 0) != reverse_pr_i) begin
                win_s[b] = pick_high(req_s[b]);
            end else begin
                win_s[b] = pick_low(req_s[b]);
            end
            for (int p = 0; p < num_ports_p; p++)
                grant_s[b][p] = req_s[b][p] & (win_s[b] == port_w_lp'(p));
            yumi_s = yumi_s | grant_s[b];
        end
    end

    // Storage array: byte-masked writes, never reset so contents survive reset_n_i.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < num_banks_p; b++)
            for (int p = 0; p < num_ports_p; p++)
                if (grant_s[b][p] && w_i[p] && !oor_s[p])
                    for (int k = 0; k < bytes_lp; k++)
                        if (mask_i[p*bytes_lp + k])
                            mem_r[b][idx_s[p]][k*8 +: 8] <= data_i[p*data_width_p + k*8 +: 8];
    end

    // Response and round-robin state; write and out-of-range responses carry zero data.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r <= '0;
            for (int p = 0; p < num_ports_p; p++) data_r[p] <= '0;
            for (int b = 0; b < num_banks_p; b++) rr_ptr_r[b] <= '0;
        end else begin
            v_r <= yumi_s;
            for (int p = 0; p < num_ports_p; p++) begin
                data_r[p] <= '0;
                for (int b = 0; b < num_banks_p; b++)
                    if (grant_s[b][p] && !w_i[p] && !oor_s[p])
                        data_r[p] <= mem_r[b][idx_s[p]];
            end
            for (int b = 0; b < num_banks_p; b++)
                if (any_s[b]) rr_ptr_r[b] <= next_ptr(win_s[b]);
        end
    end

    // Output packing.
    always_comb begin
        data_o = '0;
        for (int p = 0; p < num_ports_p; p++)
            data_o[p*data_width_p +: data_width_p] = data_r[p];
    end

    assign yumi_o = yumi_s;
    assign v_o    = v_r;

`ifdef MEM_BANKED_XBAR_CHECK_EN
    logic [num_banks_p*num_ports_p-1:0] grant_flat_s;

    // Flatten grants for the checker.
    always_comb begin
        grant_flat_s = '0;
        for (int b = 0; b < num_banks_p; b++)
            grant_flat_s[b*num_ports_p +: num_ports_p] = grant_s[b];
    end

    mem_banked_xbar_checker #(
        .num_ports_p (num_ports_p),
        .num_banks_p (num_banks_p)
    ) u_checker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .w_i       (w_i),
        .oor_i     (oor_s),
        .grant_i   (grant_flat_s)
    );
`endif

endmodule

// File: tb/tb_mem_banked_xbar.sv
// Bench for mem_banked_xbar: three configurations (fixed hi, fixed lo, 2-bank round-robin)
// driven by directed steps and random traffic, checked against an array-based reference model.
module tb_mem_banked_xbar;
    localparam int BS = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_rev  [3];
    logic        in_v    [3][3];
    logic        in_w    [3][3];
    logic [4:0]  in_addr [3][3];
    logic [31:0] in_data [3][3];
    logic [3:0]  in_mask [3][3];

    logic [1:0]  y0, y1, vo0, vo1;
    logic [63:0] do0, do1;
    logic [2:0]  y2, vo2;
    logic [95:0] do2;

    mem_banked_xbar #(.num_ports_p(2), .num_banks_p(1), .bank_size_p(BS), .data_width_p(32), .rr_lo_hi_p(0)) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .reverse_pr_i(in_rev[0]),
        .v_i({in_v[0][1], in_v[0][0]}), .w_i({in_w[0][1], in_w[0][0]}),
        .addr_i({in_addr[0][1][3:0], in_addr[0][0][3:0]}),
        .data_i({in_data[0][1], in_data[0][0]}), .mask_i({in_mask[0][1], in_mask[0][0]}),
        .yumi_o(y0), .v_o(vo0), .data_o(do0));

    mem_banked_xbar #(.num_ports_p(2), .num_banks_p(1), .bank_size_p(BS), .data_width_p(32), .rr_lo_hi_p(1)) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .reverse_pr_i(in_rev[1]),
        .v_i({in_v[1][1], in_v[1][0]}), .w_i({in_w[1][1], in_w[1][0]}),
        .addr_i({in_addr[1][1][3:0], in_addr[1][0][3:0]}),
        .data_i({in_data[1][1], in_data[1][0]}), .mask_i({in_mask[1][1], in_mask[1][0]}),
        .yumi_o(y1), .v_o(vo1), .data_o(do1));

    mem_banked_xbar #(.num_ports_p(3), .num_banks_p(2), .bank_size_p(BS), .data_width_p(32), .rr_lo_hi_p(2)) u_dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .reverse_pr_i(in_rev[2]),
        .v_i({in_v[2][2], in_v[2][1], in_v[2][0]}), .w_i({in_w[2][2], in_w[2][1], in_w[2][0]}),
        .addr_i({in_addr[2][2], in_addr[2][1], in_addr[2][0]}),
        .data_i({in_data[2][2], in_data[2][1], in_data[2][0]}),
        .mask_i({in_mask[2][2], in_mask[2][1], in_mask[2][0]}),
        .yumi_o(y2), .v_o(vo2), .data_o(do2));

    int np_c   [3] = '{2, 2, 3};
    int nb_c   [3] = '{1, 1, 2};
    int mode_c [3] = '{0, 1, 2};

    logic [31:0] mem_m [3][2][BS];
    int          ptr_m [3][2];
    logic        exp_y [3][3];
    logic        exp_v [3][3];
    logic [31:0] exp_d [3][3];
    logic        obs_y [3][3];
    int checks;
    int passes;

    function automatic logic get_y(input int d, input int p);
        case (d)
            0:       return y0[p];
            1:       return y1[p];
            default: return y2[p];
        endcase
    endfunction

    function automatic logic get_vo(input int d, input int p);
        case (d)
            0:       return vo0[p];
            1:       return vo1[p];
            default: return vo2[p];
        endcase
    endfunction

    function automatic logic [31:0] get_do(input int d, input int p);
        case (d)
            0:       return do0[p*32 +: 32];
            1:       return do1[p*32 +: 32];
            default: return do2[p*32 +: 32];
        endcase
    endfunction

    task automatic chk(input string tag, input int d, input int p, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s dut%0d port%0d: observed %h expected %h", tag, d, p, obs, exp);
    endtask

    task automatic set_req(input int d, input int p, input logic v, input logic w, input int addr,
                           input logic [31:0] data, input logic [3:0] mask);
        in_v[d][p]    = v;
        in_w[d][p]    = w;
        in_addr[d][p] = 5'(addr);
        in_data[d][p] = data;
        in_mask[d][p] = mask;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 3; p++)
                set_req(d, p, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    // Winner per bank = requester with the best score under that DUT's priority rule.
    task automatic model_grants(input int d);
        int best;
        int best_score;
        int score;
        for (int p = 0; p < 3; p++) exp_y[d][p] = 1'b0;
        for (int b = 0; b < nb_c[d]; b++) begin
            best = -1;
            best_score = 0;
            for (int p = 0; p < np_c[d]; p++) begin
                if (in_v[d][p] && (int'(in_addr[d][p]) % nb_c[d]) == b) begin
                    case (mode_c[d])
                        0:       score = in_rev[d] ? -p : p;
                        1:       score = in_rev[d] ? p : -p;
                        default: score = -((p - ptr_m[d][b] + np_c[d]) % np_c[d]);
                    endcase
                    if (best < 0 || score > best_score) begin
                        best = p;
                        best_score = score;
                    end
                end
            end
            if (best >= 0) begin
                exp_y[d][best] = 1'b1;
                ptr_m[d][b] = (best + 1) % np_c[d];
            end
        end
    endtask

    task automatic model_commit(input int d);
        int b;
        int i;
        for (int p = 0; p < np_c[d]; p++) begin
            exp_v[d][p] = exp_y[d][p];
            exp_d[d][p] = 32'h0;
            if (exp_y[d][p]) begin
                b = int'(in_addr[d][p]) % nb_c[d];
                i = int'(in_addr[d][p]) / nb_c[d];
                if (i < BS) begin
                    if (in_w[d][p]) begin
                        for (int k = 0; k < 4; k++)
                            if (in_mask[d][p][k]) mem_m[d][b][i][k*8 +: 8] = in_data[d][p][k*8 +: 8];
                    end else begin
                        exp_d[d][p] = mem_m[d][b][i];
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            model_grants(d);
            for (int p = 0; p < np_c[d]; p++) begin
                obs_y[d][p] = get_y(d, p);
                chk("yumi", d, p, 32'(obs_y[d][p]), 32'(exp_y[d][p]));
            end
            model_commit(d);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < np_c[d]; p++) begin
                chk("v_o", d, p, 32'(get_vo(d, p)), 32'(exp_v[d][p]));
                chk("data_o", d, p, get_do(d, p), exp_d[d][p]);
            end
    endtask

    // Refused requests are held; otherwise a fresh random request (sometimes out of range).
    task automatic rand_req(input int d);
        for (int p = 0; p < np_c[d]; p++) begin
            if (!(in_v[d][p] && !exp_y[d][p])) begin
                set_req(d, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, (nb_c[d] == 1) ? 15 : 31)),
                        $urandom, 4'($urandom_range(0, 15)));
            end
        end
        in_rev[d] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_rev[d] = 1'b0;
            for (int b = 0; b < 2; b++) ptr_m[d][b] = 0;
            for (int p = 0; p < 3; p++) exp_y[d][p] = 1'b0;
        end
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < np_c[d]; p++) begin
                chk("reset_v_o", d, p, 32'(get_vo(d, p)), 32'h0);
                chk("reset_data_o", d, p, get_do(d, p), 32'h0);
            end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload every in-range word so all later reads have known contents.
        for (int a = 0; a < 2 * BS; a++) begin
            idle_all();
            for (int d = 0; d < 3; d++)
                if (a < BS * nb_c[d]) set_req(d, 0, 1'b1, 1'b1, a, $urandom, 4'hF);
            cycle();
        end

        // Write/read contention on one address.
        idle_all();
        for (int d = 0; d < 3; d++) begin
            set_req(d, 1, 1'b1, 1'b1, 5, 32'hDEADBEEF, 4'hF);
            set_req(d, 0, 1'b1, 1'b0, 5, 32'h0, 4'h0);
        end
        cycle();
        chk("t1_yumi", 0, 0, {30'h0, obs_y[0][1], obs_y[0][0]}, 32'h2);
        chk("t1_v_o", 0, 0, {30'h0, vo0}, 32'h2);
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 3; p++)
                if (exp_y[d][p]) in_v[d][p] = 1'b0;
        cycle();
        chk("t1_retry", 0, 0, get_do(0, 0), 32'hDEADBEEF);
        idle_all();

        // Byte-masked write, then read back.
        for (int d = 0; d < 3; d++) set_req(d, 0, 1'b1, 1'b1, 3, 32'h11223344, 4'hF);
        cycle();
        for (int d = 0; d < 3; d++) set_req(d, 0, 1'b1, 1'b1, 3, 32'hAABBCCDD, 4'b0101);
        cycle();
        for (int d = 0; d < 3; d++) set_req(d, 0, 1'b1, 1'b0, 3, 32'h0, 4'h0);
        cycle();
        for (int d = 0; d < 3; d++) chk("t2_mask", d, 0, get_do(d, 0), 32'h11BB33DD);
        idle_all();

        // Two banks served in the same cycle.
        set_req(2, 0, 1'b1, 1'b0, 4, 32'h0, 4'h0);
        set_req(2, 1, 1'b1, 1'b0, 7, 32'h0, 4'h0);
        cycle();
        chk("t4_yumi", 2, 0, {29'h0, obs_y[2][2], obs_y[2][1], obs_y[2][0]}, 32'h3);
        chk("t4_v_o", 2, 0, {29'h0, vo2}, 32'h3);

        // Asynchronous reset while responses are valid.
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < np_c[d]; p++) begin
                chk("arst_v_o", d, p, 32'(get_vo(d, p)), 32'h0);
                chk("arst_data_o", d, p, get_do(d, p), 32'h0);
                exp_y[d][p] = 1'b0;
            end
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < 2; b++) ptr_m[d][b] = 0;
        idle_all();
        @(posedge clk);
        #1;
        chk("arst_hold", 2, 0, {29'h0, vo2}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin rotation from a fresh pointer; memory retained across reset.
        for (int p = 0; p < 3; p++) set_req(2, p, 1'b1, 1'b0, 2 * p, 32'h0, 4'h0);
        set_req(0, 0, 1'b1, 1'b0, 5, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_rr", 2, k, {29'h0, obs_y[2][2], obs_y[2][1], obs_y[2][0]}, 32'h1 << (k % 3));
        end
        chk("t3_keep", 0, 0, get_do(0, 0), 32'hDEADBEEF);
        idle_all();

        // Reversed fixed priority.
        in_rev[0] = 1'b1;
        in_rev[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b1, 1'b0, 5, 32'h0, 4'h0);
            set_req(d, 1, 1'b1, 1'b0, 5, 32'h0, 4'h0);
        end
        cycle();
        chk("t5_rev_mode0", 0, 0, {30'h0, obs_y[0][1], obs_y[0][0]}, 32'h1);
        chk("t5_rev_mode1", 1, 0, {30'h0, obs_y[1][1], obs_y[1][0]}, 32'h2);
        idle_all();
        in_rev[0] = 1'b0;
        in_rev[1] = 1'b0;

        // Out-of-range index: granted, write dropped, read returns zero.
        set_req(0, 0, 1'b1, 1'b1, 12, 32'hFFFFFFFF, 4'hF);
        cycle();
        set_req(0, 0, 1'b1, 1'b0, 12, 32'h0, 4'h0);
        cycle();
        chk("oor_yumi", 0, 0, 32'(obs_y[0][0]), 32'h1);
        chk("oor_data", 0, 0, get_do(0, 0), 32'h0);
        idle_all();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 3; d++) rand_req(d);
            cycle();
        end
        idle_all();
        cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
